seven_seg_capture: RTL and testbench
====================================

// Module: seven_seg_capture
// PURPOSE
//   Receive end of the multiplexed 7-segment display bus: samples active-low segment/anode lines.
//   Waits for each digit's pattern to settle, then inverse-decodes it back to BCD.
//   Assembles one full frame of NUM_DIGITS digits and presents it over a valid/ready handshake.
//   Used for board loopback self-check and for observing display traffic in simulation.
// PARAMETERS
//   NUM_DIGITS     4  number of multiplexed digits (anode lines)
//   STABLE_CYCLES  4  consecutive identical synchronized samples required before capture (>=2)
// PORTS
//   clk          in   1             system clock, all logic on rising edge
//   rst_n        in   1             asynchronous active-low reset
//   seg_in       in   7             segment lines {g,f,e,d,c,b,a}, active-low (0 lit)
//   an_in        in   NUM_DIGITS    anode enables, active-low, one-cold when driving
//   frame_ready  in   1             consumer accepts frame when high with frame_valid
//   frame_valid  out  1             full frame available in digits_out
//   digits_out   out  4*NUM_DIGITS  digit k at [4k+3:4k]; 0-9, F=blank, E=invalid pattern
//   digit_err    out  NUM_DIGITS    bit k set if digit k held an invalid pattern
//   overrun      out  1             sticky: a completed frame was dropped
// BEHAVIOUR
//   - Reset:
//     - all outputs 0; seen mask, stability counter and working buffer cleared.
//     - FSM goes to IDLE.
//   - Input conditioning:
//     - seg_in and an_in each pass through a 2-FF synchronizer.
//     - All further logic uses the synced values.
//   - Inverse table: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4,
//     0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111->F (no err).
//     Any other pattern -> E with err=1.
//   - FSM:
//     - IDLE: anode not exactly one low. Counter held at 0.
//       Go to SETTLE when exactly one anode is low.
//     - SETTLE: counter increments while {an,seg} equals the previous sample.
//       Any change, including a change to another valid one-cold anode, reloads the counter to 1 and stays in SETTLE.
//       All-high or multiple-low anode -> IDLE.
//       When the counter reaches STABLE_CYCLES: write the decoded digit into working buffer slot k, set seen[k], go to CAPTURED.
//     - CAPTURED: no further capture during this dwell.
//       Any change in {an,seg} -> SETTLE (counter=1), or -> IDLE if the anode is invalid.
//   - Recapturing digit k before the frame completes overwrites slot k.
//   - Frame completion: the cycle after seen becomes all ones:
//     - If !frame_valid, or frame_valid&&frame_ready: load digits_out/digit_err from the buffer and set frame_valid=1.
//     - Else: frame dropped, overrun<=1 (cleared only by reset).
//     - In both cases seen is cleared.
//   - Handshake:
//     - frame_valid stays high and digits_out stays stable until a cycle with frame_ready=1.
//     - On that cycle frame_valid drops next edge, unless a new frame loads on the same edge, in which case it stays high.
//   - Latency: 2 (sync) + STABLE_CYCLES cycles from input edge to capture; +1 to frame_valid.
//   - A reset asserted mid-frame discards the partial frame; no frame_valid is issued for it.
// CONFIGURATION
//   SEG_CAPTURE_ERRCNT_EN
//     - Defined: adds output err_count[7:0], reset to 0.
//       It increments once per capture that decodes to E and saturates at 255.
//     - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//   1. Scan digits 1,2,3,4 on an[0..3], 8 cycles each -> frame_valid=1, digits_out=16'h4321, digit_err=0.
//   2. Segment glitch lasting 2 cycles inside a dwell (STABLE_CYCLES=4) -> glitch value never captured; final frame correct.
//   3. Pattern 7'b0101010 on digit 2 -> nibble [11:8]=E, digit_err=4'b0100; all-segments-off pattern -> F, no err.
//   4. frame_ready=0 while two full frames scan -> first frame held unchanged, overrun=1, second frame dropped.
//   5. Two anodes low, or all anodes high, for 20 cycles -> no capture, seen unchanged, frame_valid stays 0.
//   6. rst_n pulsed low after 3 of 4 digits -> outputs 0; next full scan yields exactly one correct frame.
//      With SEG_CAPTURE_ERRCNT_EN, 300 invalid captures -> err_count=255.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Purpose: receive side of a multiplexed active-low 7-seg bus; decodes each settled digit back to BCD and assembles frames.
// Latency: 2 sync + STABLE_CYCLES cycles from input edge to capture, +1 cycle to frame_valid.
// Backpressure: frame held on digits_out until frame_ready; a frame completing while one is still held is dropped (sticky overrun).
// Optional: define SEG_CAPTURE_ERRCNT_EN to add err_count, a saturating count of captures that decoded to an invalid pattern.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    overrun
`ifdef SEG_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic                    capture;
    logic [6:0]              seg_s1, seg_s2, seg_p;
    logic [NUM_DIGITS-1:0]   an_s1, an_s2, an_p;
    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] buf_dig;
    logic [NUM_DIGITS-1:0]   buf_err;
    logic                    an_ok;
    logic                    changed;
    logic                    complete;
    logic [3:0]              dec_val;
    logic                    dec_err;

    // Inverse of the segment encoder; blank maps to F, anything unknown to E.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'h00;
            7'b1111001: return 5'h01;
            7'b0100100: return 5'h02;
            7'b0110000: return 5'h03;
            7'b0011001: return 5'h04;
            7'b0010010: return 5'h05;
            7'b0000010: return 5'h06;
            7'b1111000: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0010000: return 5'h09;
            7'b1111111: return 5'h0F;
            default:    return 5'h1E;
        endcase
    endfunction

    // Two-flop synchronizers plus one-cycle-old copy for change detection; idle bus is all-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_p  <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
            an_p   <= '1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
            an_s1  <= an_in;
            an_s2  <= an_s1;
            an_p   <= an_s2;
        end
    end

    assign an_ok    = $onehot(~an_s2);
    assign changed  = ({an_s2, seg_s2} != {an_p, seg_p});
    assign complete = &seen;
    assign {dec_err, dec_val} = seg_decode(seg_s2);

    // Dwell tracking: count identical samples, capture once per dwell when the count hits STABLE_CYCLES.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (an_ok) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            SETTLE: begin
                if (!an_ok) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (changed) begin
                    cnt_nxt = CW'(1);
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt_nxt == CW'(STABLE_CYCLES)) begin
                        capture   = 1'b1;
                        state_nxt = CAPTURED;
                    end
                end
            end
            CAPTURED: begin
                if (!an_ok) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (changed) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and dwell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Working buffer and seen mask; the active anode is one-cold, so ~an_s2 is the slot's one-hot bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_dig <= '0;
            buf_err <= '0;
            seen    <= '0;
        end else begin
            seen <= (complete ? '0 : seen) | (capture ? ~an_s2 : '0);
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (capture && !an_s2[k]) begin
                    buf_dig[4*k +: 4] <= dec_val;
                    buf_err[k]        <= dec_err;
                end
            end
        end
    end

    // Output frame register with valid/ready hold; a completed frame that cannot load is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            digits_out  <= '0;
            digit_err   <= '0;
            overrun     <= 1'b0;
        end else if (complete) begin
            if (!frame_valid || frame_ready) begin
                frame_valid <= 1'b1;
                digits_out  <= buf_dig;
                digit_err   <= buf_err;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

`ifdef SEG_CAPTURE_ERRCNT_EN
    // Saturating count of captures that decoded to an invalid pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (capture && dec_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: expected frames queued at stimulus time, popped on handshake.
// Timing: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Directed scans cover normal frames, glitch rejection, invalid/blank patterns, overrun, bad anodes and mid-frame reset.
module tb_seven_seg_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        frame_ready;
    logic        frame_valid;
    logic [15:0] digits_out;
    logic [3:0]  digit_err;
    logic        overrun;
`ifdef SEG_CAPTURE_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [19:0] exp_q[$];
    logic [6:0]  seg_tab [0:9];

    seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .an_in(an_in),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .digits_out(digits_out),
        .digit_err(digit_err),
        .overrun(overrun)
`ifdef SEG_CAPTURE_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int k, input logic [6:0] s, input int n);
        logic [3:0] a;
        a        = 4'hF;
        a[k]     = 1'b0;
        an_in    = a;
        seg_in   = s;
        cycles(n);
    endtask

    task automatic go_idle(input int n);
        an_in  = 4'hF;
        seg_in = 7'h7F;
        cycles(n);
    endtask

    task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
        dwell(0, s0, 8);
        dwell(1, s1, 8);
        dwell(2, s2, 8);
        dwell(3, s3, 8);
    endtask

    // Monitor: every accepted frame must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("frame_digits", {16'd0, digits_out}, {16'd0, e[15:0]});
                check("frame_err", {28'd0, digit_err}, {28'd0, e[19:16]});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        rst_n       = 1'b0;
        an_in       = 4'hF;
        seg_in      = 7'h7F;
        frame_ready = 1'b1;
        cycles(3);
        check("reset_valid", {31'd0, frame_valid}, 32'd0);
        check("reset_digits", {16'd0, digits_out}, 32'd0);
        check("reset_err", {28'd0, digit_err}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Basic scan 1,2,3,4
        exp_q.push_back({4'b0000, 16'h4321});
        scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4]);
        go_idle(6);
        check("t1_overrun", {31'd0, overrun}, 32'd0);

        // Two-cycle glitch inside digit 1's dwell must not be captured
        exp_q.push_back({4'b0000, 16'h6789});
        dwell(0, seg_tab[9], 8);
        dwell(1, seg_tab[8], 3);
        dwell(1, seg_tab[0], 2);
        dwell(1, seg_tab[8], 7);
        dwell(2, seg_tab[7], 8);
        dwell(3, seg_tab[6], 8);
        go_idle(6);

        // Blank, 5, invalid, 0
        exp_q.push_back({4'b0100, 16'h0E5F});
        scan(7'b1111111, seg_tab[5], 7'b0101010, seg_tab[0]);
        go_idle(6);

        // Backpressure: first frame held, second dropped
        frame_ready = 1'b0;
        exp_q.push_back({4'b0000, 16'h4321});
        scan(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4]);
        go_idle(6);
        check("t4_valid_held", {31'd0, frame_valid}, 32'd1);
        check("t4_digits_first", {16'd0, digits_out}, {16'd0, 16'h4321});
        scan(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8]);
        go_idle(6);
        check("t4_overrun", {31'd0, overrun}, 32'd1);
        check("t4_digits_still", {16'd0, digits_out}, {16'd0, 16'h4321});
        frame_ready = 1'b1;
        cycles(1);
        check("t4_valid_drop", {31'd0, frame_valid}, 32'd0);
        go_idle(4);

        // Invalid anode states keep the partial frame untouched
        exp_q.push_back({4'b0000, 16'h3210});
        dwell(0, seg_tab[0], 8);
        dwell(1, seg_tab[1], 8);
        dwell(2, seg_tab[2], 8);
        an_in  = 4'b1100;
        seg_in = seg_tab[8];
        cycles(20);
        an_in  = 4'b1111;
        cycles(20);
        check("t5_no_frame", {31'd0, frame_valid}, 32'd0);
        dwell(3, seg_tab[3], 8);
        go_idle(6);

        // Reset after three digits discards the partial frame
        dwell(0, seg_tab[9], 8);
        dwell(1, seg_tab[9], 8);
        dwell(2, seg_tab[9], 8);
        go_idle(1);
        rst_n = 1'b0;
        cycles(2);
        check("t6_reset_valid", {31'd0, frame_valid}, 32'd0);
        check("t6_reset_digits", {16'd0, digits_out}, 32'd0);
        check("t6_reset_overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        cycles(2);
        exp_q.push_back({4'b0000, 16'h8765});
        scan(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8]);
        go_idle(6);

`ifdef SEG_CAPTURE_ERRCNT_EN
        // 300 invalid captures on digit 0 saturate the counter
        for (int i = 0; i < 300; i++) begin
            dwell(0, 7'b0101010, 6);
            go_idle(2);
        end
        check("err_count_sat", {24'd0, err_count}, 32'd255);
`endif

        go_idle(10);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
